// File: rtl/rf_scoreboard_if.sv
// rtl/rf_scoreboard_if.sv - decode/writeback bus of the scoreboarded register file
interface rf_scoreboard_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 2
);
  logic [ADDR_BITS-1:0] read_addr_1;
  logic [ADDR_BITS-1:0] read_addr_2;
  logic [WORD_SIZE-1:0] read_data_1;
  logic [WORD_SIZE-1:0] read_data_2;
  logic                 read_busy_1;
  logic                 read_busy_2;
  logic                 write_en;
  logic [ADDR_BITS-1:0] write_addr;
  logic [WORD_SIZE-1:0] write_data;
  logic                 reserve_en;
  logic [ADDR_BITS-1:0] reserve_addr;
  logic                 clear_req;
  logic                 clear_busy;
  logic                 clear_done;
  logic [ADDR_BITS:0]   pending_count;

  modport master (
    output read_addr_1, read_addr_2, write_en, write_addr, write_data,
           reserve_en, reserve_addr, clear_req,
    input  read_data_1, read_data_2, read_busy_1, read_busy_2,
           clear_busy, clear_done, pending_count
  );

  modport slave (
    input  read_addr_1, read_addr_2, write_en, write_addr, write_data,
           reserve_en, reserve_addr, clear_req,
    output read_data_1, read_data_2, read_busy_1, read_busy_2,
           clear_busy, clear_done, pending_count
  );
endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - 2R/1W register file with pending-write scoreboard,
// write-to-read bypass, optional zero register and multi-cycle soft clear
module rf_scoreboard #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 2,
  parameter int BYPASS    = 1,
  parameter int R0_ZERO   = 0
) (
  input  logic clk,
  input  logic reset_n,
  rf_scoreboard_if.slave bus
);
  localparam int REG_SIZE = 2**ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(REG_SIZE - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t               state_q;
  logic [ADDR_BITS-1:0] clr_idx_q;
  logic                 clear_busy_q;
  logic                 clear_done_q;
  logic [WORD_SIZE-1:0] mem_q [REG_SIZE];
  logic [REG_SIZE-1:0]  busy_q, busy_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 idle, wr_ok, rsv_ok;

  function automatic logic is_zero_reg(input logic [ADDR_BITS-1:0] a);
    return (R0_ZERO != 0) && (a == '0);
  endfunction

  assign idle   = (state_q == IDLE);
  assign wr_ok  = idle && bus.write_en && !is_zero_reg(bus.write_addr);
  assign rsv_ok = idle && bus.reserve_en && !is_zero_reg(bus.reserve_addr);

  // Reserve is applied after the write so a same-address pair leaves the new producer pending.
  always_comb begin
    busy_d = busy_q;
    if (state_q == CLEAR) busy_d[clr_idx_q] = 1'b0;
    if (wr_ok)            busy_d[bus.write_addr] = 1'b0;
    if (rsv_ok)           busy_d[bus.reserve_addr] = 1'b1;
    count_d = '0;
    for (int i = 0; i < REG_SIZE; i++) begin
      count_d = count_d + {{ADDR_BITS{1'b0}}, busy_d[i]};
    end
  end

  always_comb begin
    bus.read_data_1 = mem_q[bus.read_addr_1];
    bus.read_busy_1 = busy_q[bus.read_addr_1];
    if (is_zero_reg(bus.read_addr_1)) begin
      bus.read_data_1 = '0;
      bus.read_busy_1 = 1'b0;
    end else if ((BYPASS != 0) && idle && bus.write_en && (bus.write_addr == bus.read_addr_1)) begin
      bus.read_data_1 = bus.write_data;
      bus.read_busy_1 = 1'b0;
    end
  end

  always_comb begin
    bus.read_data_2 = mem_q[bus.read_addr_2];
    bus.read_busy_2 = busy_q[bus.read_addr_2];
    if (is_zero_reg(bus.read_addr_2)) begin
      bus.read_data_2 = '0;
      bus.read_busy_2 = 1'b0;
    end else if ((BYPASS != 0) && idle && bus.write_en && (bus.write_addr == bus.read_addr_2)) begin
      bus.read_data_2 = bus.write_data;
      bus.read_busy_2 = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      clr_idx_q    <= '0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
      busy_q       <= '0;
      count_q      <= '0;
      for (int i = 0; i < REG_SIZE; i++) mem_q[i] <= '0;
    end else begin
      busy_q       <= busy_d;
      count_q      <= count_d;
      clear_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_ok) mem_q[bus.write_addr] <= bus.write_data;
          if (bus.clear_req) begin
            state_q      <= CLEAR;
            clr_idx_q    <= '0;
            clear_busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          mem_q[clr_idx_q] <= '0;
          clr_idx_q        <= clr_idx_q + 1'b1;
          if (clr_idx_q == LAST_IDX) begin
            state_q      <= DONE;
            clear_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q      <= IDLE;
          clear_busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.clear_busy    = clear_busy_q;
  assign bus.clear_done    = clear_done_q;
  assign bus.pending_count = count_q;
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb/tb_rf_scoreboard.sv - self-checking bench for rf_scoreboard
module tb_rf_scoreboard;
  logic clk = 1'b0;
  logic rst0_n = 1'b0;
  logic rst1_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [2:0] exp_q [$];

  always #5 clk = ~clk;

  rf_scoreboard_if #(.WORD_SIZE(16), .ADDR_BITS(2)) bus0 ();
  rf_scoreboard_if #(.WORD_SIZE(16), .ADDR_BITS(2)) bus1 ();

  rf_scoreboard #(.WORD_SIZE(16), .ADDR_BITS(2), .BYPASS(1), .R0_ZERO(0))
    dut0 (.clk(clk), .reset_n(rst0_n), .bus(bus0));
  rf_scoreboard #(.WORD_SIZE(16), .ADDR_BITS(2), .BYPASS(1), .R0_ZERO(1))
    dut1 (.clk(clk), .reset_n(rst1_n), .bus(bus1));

  typedef struct {
    logic        wen;
    logic [1:0]  waddr;
    logic [15:0] wdata;
    logic        ren;
    logic [1:0]  raddr;
    logic [1:0]  ra1;
    logic [1:0]  ra2;
    logic [15:0] e_rd1;
    logic        e_b1;
    logic [15:0] e_rd2;
    logic        e_b2;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus0();
    bus0.write_en = 1'b0; bus0.write_addr = '0; bus0.write_data = '0;
    bus0.reserve_en = 1'b0; bus0.reserve_addr = '0; bus0.clear_req = 1'b0;
    bus0.read_addr_1 = '0; bus0.read_addr_2 = '0;
  endtask

  task automatic idle_bus1();
    bus1.write_en = 1'b0; bus1.write_addr = '0; bus1.write_data = '0;
    bus1.reserve_en = 1'b0; bus1.reserve_addr = '0; bus1.clear_req = 1'b0;
    bus1.read_addr_1 = '0; bus1.read_addr_2 = '0;
  endtask

  task automatic write0(input logic [1:0] a, input logic [15:0] d);
    bus0.write_en = 1'b1; bus0.write_addr = a; bus0.write_data = d;
    step();
    bus0.write_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;
    int done_pulses;
    logic [2:0] exp_cnt;

    idle_bus0();
    idle_bus1();
    repeat (2) @(posedge clk);
    #1;
    chk("reset count", bus0.pending_count, 0);
    chk("reset clear_busy", bus0.clear_busy, 0);
    chk("reset clear_done", bus0.clear_done, 0);
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    bus0.read_addr_1 = 2'd2;
    #1;
    chk("reset rd1", bus0.read_data_1, 0);
    chk("reset busy1", bus0.read_busy_1, 0);

    // Write then async reset between edges.
    step();
    write0(2'd2, 16'h1234);
    chk("wr r2 rd1", bus0.read_data_1, 16'h1234);
    chk("wr r2 busy1", bus0.read_busy_1, 0);
    #2 rst0_n = 1'b0;
    #1;
    chk("async reset rd1", bus0.read_data_1, 0);
    chk("async reset count", bus0.pending_count, 0);
    step();
    rst0_n = 1'b1;

    //          wen  wa    wdata     ren  ra    ra1   ra2   e_rd1     b1    e_rd2     b2    cnt
    vecs.push_back('{1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 2'd0, 2'd1, 16'h0000, 1'b0, 16'h0000, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 2'd2, 16'h1234, 1'b0, 2'd0, 2'd2, 2'd0, 16'h1234, 1'b0, 16'h0000, 1'b0, 3'd0});
    vecs.push_back('{1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 2'd2, 2'd3, 16'h1234, 1'b0, 16'h0000, 1'b0, 3'd0});
    vecs.push_back('{1'b0, 2'd0, 16'h0000, 1'b1, 2'd1, 2'd1, 2'd2, 16'h0000, 1'b0, 16'h1234, 1'b0, 3'd1});
    vecs.push_back('{1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 2'd1, 2'd0, 16'h0000, 1'b1, 16'h0000, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 2'd1, 16'hBEEF, 1'b0, 2'd0, 2'd1, 2'd2, 16'hBEEF, 1'b0, 16'h1234, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 2'd3, 16'h0055, 1'b1, 2'd3, 2'd3, 2'd1, 16'h0055, 1'b0, 16'hBEEF, 1'b0, 3'd1});
    vecs.push_back('{1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 2'd3, 2'd2, 16'h0055, 1'b1, 16'h1234, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 2'd2, 16'hA5A5, 1'b1, 2'd0, 2'd2, 2'd0, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 3'd2});
    vecs.push_back('{1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 2'd0, 2'd2, 16'h0000, 1'b1, 16'hA5A5, 1'b0, 3'd2});
    vecs.push_back('{1'b0, 2'd0, 16'h0000, 1'b1, 2'd1, 2'd1, 2'd3, 16'hBEEF, 1'b0, 16'h0055, 1'b1, 3'd3});
    vecs.push_back('{1'b0, 2'd0, 16'h0000, 1'b1, 2'd2, 2'd2, 2'd1, 16'hA5A5, 1'b0, 16'hBEEF, 1'b1, 3'd4});
    vecs.push_back('{1'b0, 2'd0, 16'h0000, 1'b1, 2'd1, 2'd0, 2'd2, 16'h0000, 1'b1, 16'hA5A5, 1'b1, 3'd4});
    vecs.push_back('{1'b1, 2'd3, 16'hFFFF, 1'b0, 2'd0, 2'd3, 2'd1, 16'hFFFF, 1'b0, 16'hBEEF, 1'b1, 3'd3});

    foreach (vecs[i]) begin
      bus0.write_en     = vecs[i].wen;
      bus0.write_addr   = vecs[i].waddr;
      bus0.write_data   = vecs[i].wdata;
      bus0.reserve_en   = vecs[i].ren;
      bus0.reserve_addr = vecs[i].raddr;
      bus0.read_addr_1  = vecs[i].ra1;
      bus0.read_addr_2  = vecs[i].ra2;
      exp_q.push_back(vecs[i].e_cnt);
      #1;
      chk($sformatf("vec%0d rd1", i), bus0.read_data_1, vecs[i].e_rd1);
      chk($sformatf("vec%0d busy1", i), bus0.read_busy_1, vecs[i].e_b1);
      chk($sformatf("vec%0d rd2", i), bus0.read_data_2, vecs[i].e_rd2);
      chk($sformatf("vec%0d busy2", i), bus0.read_busy_2, vecs[i].e_b2);
      step();
      exp_cnt = exp_q.pop_front();
      chk($sformatf("vec%0d count", i), bus0.pending_count, exp_cnt);
    end
    idle_bus0();

    // Soft clear with a write issued while the engine runs.
    for (int a = 0; a < 4; a++) write0(a[1:0], 16'hFFFF);
    bus0.reserve_en = 1'b1; bus0.reserve_addr = 2'd2;
    step();
    bus0.reserve_en = 1'b0;
    chk("pre-clear count", bus0.pending_count, 1);
    bus0.clear_req = 1'b1;
    step();
    bus0.clear_req = 1'b0;
    bus0.write_en = 1'b1; bus0.write_addr = 2'd1; bus0.write_data = 16'h1234;
    bus0.read_addr_1 = 2'd1;
    bus0.read_addr_2 = 2'd0;
    #1;
    chk("clear no bypass rd1", bus0.read_data_1, 16'hFFFF);
    busy_cycles = 0;
    done_pulses = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (!bus0.clear_busy) break;
      busy_cycles++;
      if (bus0.clear_done) done_pulses++;
      if (cyc == 0) chk("partial r0 before", bus0.read_data_2, 16'hFFFF);
      if (cyc == 1) chk("partial r0 after", bus0.read_data_2, 16'h0000);
      step();
      bus0.write_en = 1'b0;
    end
    chk("clear_busy cycles", busy_cycles, 5);
    chk("clear_done pulses", done_pulses, 1);
    for (int a = 0; a < 4; a++) begin
      bus0.read_addr_1 = a[1:0];
      #1;
      chk($sformatf("post-clear r%0d", a), bus0.read_data_1, 0);
    end
    chk("post-clear count", bus0.pending_count, 0);
    idle_bus0();

    // Hardwired-zero instance.
    bus1.write_en = 1'b1; bus1.write_addr = 2'd0; bus1.write_data = 16'hAAAA;
    bus1.reserve_en = 1'b1; bus1.reserve_addr = 2'd0;
    #1;
    chk("r0z comb rd1", bus1.read_data_1, 0);
    chk("r0z comb busy1", bus1.read_busy_1, 0);
    step();
    idle_bus1();
    #1;
    chk("r0z rd1", bus1.read_data_1, 0);
    chk("r0z busy1", bus1.read_busy_1, 0);
    chk("r0z count", bus1.pending_count, 0);
    bus1.clear_req = 1'b1;
    step();
    bus1.clear_req = 1'b0;
    step();
    chk("r0z clear_busy mid", bus1.clear_busy, 1);
    #2 rst1_n = 1'b0;
    #1;
    chk("r0z reset clear_busy", bus1.clear_busy, 0);
    chk("r0z reset clear_done", bus1.clear_done, 0);
    step();
    rst1_n = 1'b1;
    step();
    chk("r0z idle after reset", bus1.clear_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
